// File: rtl/seg7_pkg.sv
// Shared types, blank code and active-low hex segment table for the 7-segment scan driver.
package seg7_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [SEG_W-1:0]   seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low codes, bit0=a ... bit6=g, for 0-9 then A b C d E F.
  localparam seg_t SEG_CODES [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load handshake between the producer of display data and the scan driver.
// The blink_mask signal exists only when SEG7_BLINK_EN is defined.
interface seg7_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
);

  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
`ifdef SEG7_BLINK_EN
  logic [NUM_DIGITS-1:0]   blink_mask;
`endif
  logic                    update_ack;

`ifdef SEG7_BLINK_EN
  modport master (output load, digits_in, blank_mask, blink_mask, input update_ack);
  modport slave  (input load, digits_in, blank_mask, blink_mask, output update_ack);
`else
  modport master (output load, digits_in, blank_mask, input update_ack);
  modport slave  (input load, digits_in, blank_mask, output update_ack);
`endif

endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational hex digit to active-low 7-segment decoder.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  digit_t digit,
  output seg_t   seg_n_c
);

  always_comb seg_n_c = SEG_CODES[digit];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment scan driver with tear-free frame updates.
// Optional blinking is built when SEG7_BLINK_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000
`ifdef SEG7_BLINK_EN
  ,
  parameter int unsigned BLINK_FRAMES = 64
`endif
)(
  input  logic                  clk,
  input  logic                  rst_n,
  seg7_scan_driver_if.slave     ld,
  output seg_t                  seg_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame_done
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
  localparam int unsigned DIG_W = DIGIT_W * NUM_DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(REFRESH_DIV - 1);

  logic                  tick_c, wrap_c;
  logic [PRE_W-1:0]      presc_q, presc_nxt;
  logic [IDX_W-1:0]      idx_q, idx_nxt;
  logic [DIG_W-1:0]      pend_digits_q, pend_digits_nxt;
  logic [DIG_W-1:0]      act_digits_q, act_digits_nxt;
  logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_nxt;
  logic [NUM_DIGITS-1:0] act_blank_q, act_blank_nxt;
  logic [NUM_DIGITS-1:0] blank_eff;
  logic                  pend_flag_q, pend_flag_nxt;
  logic                  update_ack_q, update_ack_nxt;
  logic                  frame_done_nxt;
  seg_t                  seg_nxt, dec_seg;
  logic [NUM_DIGITS-1:0] an_nxt;
  digit_t                digit_sel;
  logic                  blank_sel;

`ifdef SEG7_BLINK_EN
  localparam int unsigned FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FR_W-1:0] LAST_FR = FR_W'(BLINK_FRAMES - 1);

  logic [NUM_DIGITS-1:0] pend_blink_q, pend_blink_nxt;
  logic [NUM_DIGITS-1:0] act_blink_q, act_blink_nxt;
  logic [FR_W-1:0]       frame_cnt_q, frame_cnt_nxt;
  logic                  phase_q, phase_nxt;
`endif

  assign ld.update_ack = update_ack_q;

  // Prescaler, scan index and pending/active data next-state.
  always_comb begin
    tick_c          = (presc_q == LAST_PRE);
    wrap_c          = tick_c && (idx_q == LAST_IDX);
    presc_nxt       = tick_c ? '0 : presc_q + PRE_W'(1);
    idx_nxt         = idx_q;
    pend_digits_nxt = pend_digits_q;
    pend_blank_nxt  = pend_blank_q;
    act_digits_nxt  = act_digits_q;
    act_blank_nxt   = act_blank_q;
    pend_flag_nxt   = pend_flag_q;
    update_ack_nxt  = 1'b0;
    frame_done_nxt  = wrap_c;
`ifdef SEG7_BLINK_EN
    pend_blink_nxt  = pend_blink_q;
    act_blink_nxt   = act_blink_q;
    frame_cnt_nxt   = frame_cnt_q;
    phase_nxt       = phase_q;
`endif

    if (tick_c) begin
      idx_nxt = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end

    // A load coinciding with the frame boundary bypasses the pending stage.
    if (wrap_c && ld.load) begin
      act_digits_nxt = ld.digits_in;
      act_blank_nxt  = ld.blank_mask;
`ifdef SEG7_BLINK_EN
      act_blink_nxt  = ld.blink_mask;
`endif
      pend_flag_nxt  = 1'b0;
      update_ack_nxt = 1'b1;
    end else if (wrap_c && pend_flag_q) begin
      act_digits_nxt = pend_digits_q;
      act_blank_nxt  = pend_blank_q;
`ifdef SEG7_BLINK_EN
      act_blink_nxt  = pend_blink_q;
`endif
      pend_flag_nxt  = 1'b0;
      update_ack_nxt = 1'b1;
    end else if (ld.load) begin
      pend_digits_nxt = ld.digits_in;
      pend_blank_nxt  = ld.blank_mask;
`ifdef SEG7_BLINK_EN
      pend_blink_nxt  = ld.blink_mask;
`endif
      pend_flag_nxt   = 1'b1;
    end

`ifdef SEG7_BLINK_EN
    if (wrap_c) begin
      if (frame_cnt_q == LAST_FR) begin
        frame_cnt_nxt = '0;
        phase_nxt     = ~phase_q;
      end else begin
        frame_cnt_nxt = frame_cnt_q + FR_W'(1);
      end
    end
    blank_eff = act_blank_nxt | (phase_nxt ? act_blink_nxt : '0);
`else
    blank_eff = act_blank_nxt;
`endif

    // Select the digit that becomes visible after this edge.
    digit_sel = '0;
    blank_sel = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        digit_sel = act_digits_nxt[DIGIT_W*i +: DIGIT_W];
        blank_sel = blank_eff[i];
      end
    end
  end

  seg7_hex_decoder u_dec (
    .digit   (digit_sel),
    .seg_n_c (dec_seg)
  );

  // Display pins change only on a slot tick.
  always_comb begin
    seg_nxt = seg_n;
    an_nxt  = an_n;
    if (tick_c) begin
      if (blank_sel) begin
        seg_nxt = SEG_BLANK;
        an_nxt  = '1;
      end else begin
        seg_nxt = dec_seg;
        an_nxt  = ~(NUM_DIGITS'(1) << idx_nxt);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      idx_q         <= LAST_IDX;
      pend_digits_q <= '0;
      pend_blank_q  <= '1;
      act_digits_q  <= '0;
      act_blank_q   <= '1;
      pend_flag_q   <= 1'b0;
      update_ack_q  <= 1'b0;
      frame_done    <= 1'b0;
      seg_n         <= SEG_BLANK;
      an_n          <= '1;
    end else begin
      presc_q       <= presc_nxt;
      idx_q         <= idx_nxt;
      pend_digits_q <= pend_digits_nxt;
      pend_blank_q  <= pend_blank_nxt;
      act_digits_q  <= act_digits_nxt;
      act_blank_q   <= act_blank_nxt;
      pend_flag_q   <= pend_flag_nxt;
      update_ack_q  <= update_ack_nxt;
      frame_done    <= frame_done_nxt;
      seg_n         <= seg_nxt;
      an_n          <= an_nxt;
    end
  end

`ifdef SEG7_BLINK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_blink_q <= '0;
      act_blink_q  <= '0;
      frame_cnt_q  <= '0;
      phase_q      <= 1'b0;
    end else begin
      pend_blink_q <= pend_blink_nxt;
      act_blink_q  <= act_blink_nxt;
      frame_cnt_q  <= frame_cnt_nxt;
      phase_q      <= phase_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: NUM_DIGITS=4, REFRESH_DIV=4 (BLINK_FRAMES=2 with SEG7_BLINK_EN).
module tb_seg7_scan_driver;

  localparam int unsigned ND  = 4;
  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int          errors = 0;
  int          checks = 0;
  int          pe_cnt;
  int          slot_no = 0;
  logic [12:0] exp_q[$];
  logic [12:0] mon_exp;
  logic [12:0] mon_act;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (DIV)
`ifdef SEG7_BLINK_EN
    ,
    .BLINK_FRAMES(2)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld         (bus),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Rising edges since reset release; a slot starts after every DIV-th edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pe_cnt <= 0;
    else        pe_cnt <= pe_cnt + 1;
  end

  // Monitor: compare each new slot against the scoreboard; pulses must be zero between slots.
  always @(negedge clk) begin
    if (rst_n && pe_cnt != 0) begin
      if (pe_cnt % DIV == 0) begin
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          mon_act = {an_n, seg_n, frame_done, bus.update_ack};
          slot_no++;
          checks++;
          if (mon_act !== mon_exp) begin
            errors++;
            $display("FAIL slot %0d: got an=%h seg=%h fd=%b ack=%b, expected an=%h seg=%h fd=%b ack=%b",
                     slot_no, mon_act[12:9], mon_act[8:2], mon_act[1], mon_act[0],
                     mon_exp[12:9], mon_exp[8:2], mon_exp[1], mon_exp[0]);
          end
        end
      end else begin
        chk("pulse_idle", {14'h0, frame_done, bus.update_ack}, 16'h0);
      end
    end
  end

  // One display slot: optional load at rising edge 'at' (1..4; 4 is the tick edge), then expected output.
  task automatic slot(input bit ld, input int at, input logic [15:0] d, input logic [3:0] bm,
                      input logic [3:0] bk, input logic [3:0] an, input logic [6:0] seg,
                      input bit fd, input bit ack);
    exp_q.push_back({an, seg, fd, ack});
    for (int m = 1; m <= int'(DIV); m++) begin
      bus.load       = ld && (m == at);
      bus.digits_in  = bus.load ? d  : 16'($urandom);
      bus.blank_mask = bus.load ? bm : 4'($urandom);
`ifdef SEG7_BLINK_EN
      bus.blink_mask = bus.load ? bk : 4'($urandom);
`else
      if (bk != 4'h0) $display("note: blink mask ignored in this build");
`endif
      @(negedge clk);
    end
    bus.load = 1'b0;
  endtask

  task automatic show(input logic [3:0] an, input logic [6:0] seg, input bit fd, input bit ack);
    slot(1'b0, 0, 16'h0, 4'h0, 4'h0, an, seg, fd, ack);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", 16'(exp_q.size()), 16'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.load       = 1'b0;
    bus.digits_in  = '0;
    bus.blank_mask = '0;
`ifdef SEG7_BLINK_EN
    bus.blink_mask = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_seg", 16'(seg_n), 16'h007F);
    chk("rst_an", 16'(an_n), 16'h000F);
    chk("rst_fd", 16'(frame_done), 16'h0);
    chk("rst_ack", 16'(bus.update_ack), 16'h0);
    rst_n = 1'b1;

    // No load: blank display, frame_done on the first tick and every 16 cycles.
    show(4'hF, 7'h7F, 1, 0); show(4'hF, 7'h7F, 0, 0); show(4'hF, 7'h7F, 0, 0); show(4'hF, 7'h7F, 0, 0);
    show(4'hF, 7'h7F, 1, 0); show(4'hF, 7'h7F, 0, 0); show(4'hF, 7'h7F, 0, 0); show(4'hF, 7'h7F, 0, 0);

    // 8A10 loaded before a boundary.
    slot(1, 1, 16'h8A10, 4'h0, 4'h0, 4'hE, 7'h40, 1, 1);
    show(4'hD, 7'h79, 0, 0); show(4'hB, 7'h08, 0, 0); show(4'h7, 7'h00, 0, 0);

    // 1234 then a mid-frame FFFF that waits for the next boundary.
    slot(1, 2, 16'h1234, 4'h0, 4'h0, 4'hE, 7'h19, 1, 1);
    show(4'hD, 7'h30, 0, 0); show(4'hB, 7'h24, 0, 0); show(4'h7, 7'h79, 0, 0);
    show(4'hE, 7'h19, 1, 0);
    slot(1, 2, 16'hFFFF, 4'h0, 4'h0, 4'hD, 7'h30, 0, 0);
    show(4'hB, 7'h24, 0, 0); show(4'h7, 7'h79, 0, 0);
    show(4'hE, 7'h0E, 1, 1); show(4'hD, 7'h0E, 0, 0); show(4'hB, 7'h0E, 0, 0); show(4'h7, 7'h0E, 0, 0);

    // Two loads in one frame: only the latest, one ack.
    show(4'hE, 7'h0E, 1, 0);
    slot(1, 1, 16'h1111, 4'h0, 4'h0, 4'hD, 7'h0E, 0, 0);
    slot(1, 3, 16'h2222, 4'h0, 4'h0, 4'hB, 7'h0E, 0, 0);
    show(4'h7, 7'h0E, 0, 0);
    show(4'hE, 7'h24, 1, 1); show(4'hD, 7'h24, 0, 0); show(4'hB, 7'h24, 0, 0); show(4'h7, 7'h24, 0, 0);
    show(4'hE, 7'h24, 1, 0); show(4'hD, 7'h24, 0, 0); show(4'hB, 7'h24, 0, 0); show(4'h7, 7'h24, 0, 0);

    // Load on the boundary tick itself.
    slot(1, 4, 16'h0009, 4'h0, 4'h0, 4'hE, 7'h10, 1, 1);
    show(4'hD, 7'h40, 0, 0); show(4'hB, 7'h40, 0, 0); show(4'h7, 7'h40, 0, 0);
    show(4'hE, 7'h10, 1, 0);

    // 5555 with digit 1 blanked.
    slot(1, 1, 16'h5555, 4'b0010, 4'h0, 4'hD, 7'h40, 0, 0);
    show(4'hB, 7'h40, 0, 0); show(4'h7, 7'h40, 0, 0);
    show(4'hE, 7'h12, 1, 1); show(4'hF, 7'h7F, 0, 0); show(4'hB, 7'h12, 0, 0); show(4'h7, 7'h12, 0, 0);
    drain();

    // Mid-frame reset with a pending load; load during reset is ignored.
    bus.load = 1'b1; bus.digits_in = 16'h1234; bus.blank_mask = 4'h0;
    @(negedge clk);
    bus.load = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_seg", 16'(seg_n), 16'h007F);
    chk("async_an", 16'(an_n), 16'h000F);
    @(negedge clk);
    bus.load = 1'b1; bus.digits_in = 16'h7777;
    @(negedge clk);
    bus.load = 1'b0;
    chk("hold_seg", 16'(seg_n), 16'h007F);
    chk("hold_ack", 16'(bus.update_ack), 16'h0);
    rst_n = 1'b1;
    show(4'hF, 7'h7F, 1, 0); show(4'hF, 7'h7F, 0, 0); show(4'hF, 7'h7F, 0, 0); show(4'hF, 7'h7F, 0, 0);
    show(4'hF, 7'h7F, 1, 0); show(4'hF, 7'h7F, 0, 0); show(4'hF, 7'h7F, 0, 0); show(4'hF, 7'h7F, 0, 0);
    drain();

`ifdef SEG7_BLINK_EN
    // Blinking digit 0 with a two-frame half-period.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    slot(1, 1, 16'h8A10, 4'h0, 4'b0001, 4'hE, 7'h40, 1, 1);
    show(4'hD, 7'h79, 0, 0); show(4'hB, 7'h08, 0, 0); show(4'h7, 7'h00, 0, 0);
    for (int f = 2; f <= 6; f++) begin
      if (f == 2 || f == 3 || f == 6) show(4'hF, 7'h7F, 1, 0);
      else                            show(4'hE, 7'h40, 1, 0);
      show(4'hD, 7'h79, 0, 0); show(4'hB, 7'h08, 0, 0); show(4'h7, 7'h00, 0, 0);
    end
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
